// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional MULDIV_EARLY_OUT_EN: single-cycle completion for zero/overflow/trivial operands.
module muldiv_unit #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);
  localparam int unsigned CW    = $clog2(XLEN + 1);
  localparam bit          HAS_W = (XLEN == 64);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   x_q, x_d, y_q, y_d, res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              mul_q, mul_d, hi_q, hi_d, rem_q, rem_d, w_q, w_d;
  logic              ill_q, ill_d, neg_q, neg_d;

  int unsigned       op_i;
  logic              dec_mul, dec_hi, dec_rem, dec_w, dec_ill, dec_sa, dec_sb;
  logic              a_neg, b_neg;
  logic [31:0]       a_lo, b_lo, a_lo_neg, b_lo_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              accept, last, early_hit;
  logic [XLEN-1:0]   early_res;

  logic [XLEN:0]     rem_sh, diff;
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN-1:0]   dv_val, dv_fix, fix_res;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign op_i     = 32'(op);
  assign a_lo     = a[31:0];
  assign b_lo     = b[31:0];
  assign a_lo_neg = '0 - a_lo;
  assign b_lo_neg = '0 - b_lo;

  always_comb begin
    dec_mul = 1'b0;
    dec_hi  = 1'b0;
    dec_rem = 1'b0;
    dec_w   = 1'b0;
    dec_ill = 1'b0;
    dec_sa  = 1'b0;
    dec_sb  = 1'b0;
    case (op_i)
      0:  dec_mul = 1'b1;
      1:  begin dec_mul = 1'b1; dec_hi = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      2:  begin dec_mul = 1'b1; dec_hi = 1'b1; dec_sa = 1'b1; end
      3:  begin dec_mul = 1'b1; dec_hi = 1'b1; end
      4:  begin dec_sa = 1'b1; dec_sb = 1'b1; end
      5:  ;
      6:  begin dec_rem = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      7:  dec_rem = 1'b1;
      8:  begin dec_mul = 1'b1; dec_w = 1'b1; end
      9:  begin dec_w = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      10: dec_w = 1'b1;
      11: begin dec_w = 1'b1; dec_rem = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      12: begin dec_w = 1'b1; dec_rem = 1'b1; end
      default: begin dec_mul = 1'b1; dec_ill = 1'b1; end
    endcase
    if (dec_w && !HAS_W) begin
      dec_mul = 1'b1;
      dec_ill = 1'b1;
      dec_w   = 1'b0;
      dec_hi  = 1'b0;
      dec_rem = 1'b0;
      dec_sa  = 1'b0;
      dec_sb  = 1'b0;
    end
    // Work on magnitudes; the sign is restored in the final cycle.
    a_neg = dec_sa & (dec_w ? a[31] : a[XLEN-1]);
    b_neg = dec_sb & (dec_w ? b[31] : b[XLEN-1]);
    if (dec_w) begin
      a_mag = a_neg ? XLEN'(a_lo_neg) : XLEN'(a_lo);
      b_mag = b_neg ? XLEN'(b_lo_neg) : XLEN'(b_lo);
    end else begin
      a_mag = a_neg ? '0 - a : a;
      b_mag = b_neg ? '0 - b : b;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] a_ext, min_mag;
  logic            ovf;

  assign a_ext   = dec_w ? sext32(a_lo) : a;
  assign min_mag = dec_w ? XLEN'(32'h8000_0000) : (XLEN'(1) << (XLEN - 1));
  assign ovf     = dec_sa & a_neg & b_neg & (a_mag == min_mag) & (b_mag == XLEN'(1));

  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (dec_ill) begin
      early_hit = 1'b0;
    end else if (dec_mul) begin
      early_hit = (a_mag == '0) || (b_mag == '0);
    end else if (b_mag == '0) begin
      early_hit = 1'b1;
      early_res = dec_rem ? a_ext : '1;
    end else if (ovf) begin
      early_hit = 1'b1;
      early_res = dec_rem ? '0 : a_ext;
    end else if (a_mag < b_mag) begin
      early_hit = 1'b1;
      early_res = dec_rem ? a_ext : '0;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  assign accept    = in_valid & in_ready & ~flush;
  assign last      = (cnt_q == (w_q ? CW'(32) : CW'(XLEN)));
  assign rem_sh    = {acc_q[XLEN-1:0], y_q[XLEN-1]};
  assign diff      = rem_sh - {1'b0, x_q};
  assign prod_step = {acc_q[2*XLEN-2:0], 1'b0} + (y_q[XLEN-1] ? (2*XLEN)'(x_q) : '0);
  assign prod_fix  = neg_q ? '0 - acc_q : acc_q;
  assign dv_val    = rem_q ? acc_q[XLEN-1:0] : y_q;
  assign dv_fix    = neg_q ? '0 - dv_val : dv_val;

  always_comb begin
    if (ill_q) begin
      fix_res = '0;
    end else if (mul_q) begin
      fix_res = w_q ? sext32(prod_fix[31:0]) :
                hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end else begin
      fix_res = w_q ? sext32(dv_fix[31:0]) : dv_fix;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
    res_d = res_q;
    mul_d = mul_q;
    hi_d  = hi_q;
    rem_d = rem_q;
    w_d   = w_q;
    ill_d = ill_q;
    neg_d = neg_q;
    if (accept) begin
      cnt_d = '0;
      acc_d = '0;
      mul_d = dec_mul;
      hi_d  = dec_hi;
      rem_d = dec_rem;
      w_d   = dec_w;
      ill_d = dec_ill;
      // Quotient of a divide-by-zero is all ones regardless of operand signs.
      neg_d = dec_mul ? (a_neg ^ b_neg) :
              dec_rem ? a_neg : ((a_neg ^ b_neg) & (b_mag != '0));
      x_d   = dec_mul ? a_mag : b_mag;
      y_d   = dec_mul ? b_mag : a_mag;
      if (dec_w) y_d = y_d << 32;
      if (early_hit) res_d = early_res;
    end else if (state_q == CALC && !flush) begin
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        res_d = fix_res;
      end else if (mul_q) begin
        acc_d = prod_step;
        y_d   = y_q << 1;
      end else if (!diff[XLEN]) begin
        acc_d = (2*XLEN)'(diff[XLEN-1:0]);
        y_d   = {y_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = (2*XLEN)'(rem_sh[XLEN-1:0]);
        y_d   = {y_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = early_hit ? DONE : CALC;
      CALC:    if (flush) state_d = IDLE; else if (last) state_d = DONE;
      DONE:    if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign res = res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
      mul_q <= 1'b0;
      hi_q  <= 1'b0;
      rem_q <= 1'b0;
      w_q   <= 1'b0;
      ill_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
      res_q <= res_d;
      mul_q <= mul_d;
      hi_q  <= hi_d;
      rem_q <= rem_d;
      w_q   <= w_d;
      ill_q <= ill_d;
      neg_q <= neg_d;
    end
  end
endmodule
